regop_ctrl: RTL and testbench

Command sequencer and read scheduler for the operation unit plus register bank datapath. It buffers write commands (operands X/Y, op select C, destination register) in a small FIFO and issues one per cycle to the datapath's write side. It also serves read requests through the bank's SEL/R mux, stalling any read whose register still has a queued write. It sits between the system-side command/read interfaces and the datapath's X, Y, C, w_addr, en_addr, SEL and R ports.

---
 rtl/regop_ctrl.sv | 139 +++++++++++++
 tb/tb_regop_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regop_ctrl.sv
// Command sequencer and read scheduler for the operation unit / register bank
// datapath: a write-command FIFO issuing one write per cycle, plus a hazard-aware read FSM.
module regop_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_x,
    input  logic [7:0]              cmd_y,
    input  logic                    cmd_c,
    input  logic [2:0]              cmd_dst,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [2:0]              rd_addr,
    output logic                    rd_data_valid,
    output logic [15:0]             rd_data,
    output logic [7:0]              X,
    output logic [7:0]              Y,
    output logic                    C,
    output logic [2:0]              w_addr,
    output logic                    en_addr,
    output logic [2:0]              SEL,
    input  logic [15:0]             R,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [2:0] dst;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} rd_state_t;

    cmd_t          mem [DEPTH];
    cmd_t          cmd_in;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;
    logic          hazard;
    rd_state_t     state;
    rd_state_t     state_next;

    assign cmd_in    = {cmd_x, cmd_y, cmd_c, cmd_dst};
    assign cmd_ready = count < FULL_COUNT;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = en_addr;

    // NOTE: every output gets a default before any condition, so no path leaves one unassigned (no latch).
    always_comb begin
        en_addr = 1'b0;
        X       = '0;
        Y       = '0;
        C       = 1'b0;
        w_addr  = '0;
        if (count != '0) begin
            en_addr = run;
            X       = mem[head].x;
            Y       = mem[head].y;
            C       = mem[head].c;
            w_addr  = mem[head].dst;
        end
    end

    // An entry is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head} < count) && (mem[PW'(i)].dst == rd_addr))
                hazard = 1'b1;
        end
    end

    // NOTE: storage carries no reset; an entry is only ever observed while count marks it live.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= cmd_in;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            SEL     <= '0;
            rd_data <= '0;
        end else begin
            state <= state_next;
            if (rd_ready)
                SEL <= rd_addr;
            // Capture happens on the same edge a SETTLE-cycle write lands, so R is still the old value.
            if (state == SETTLE)
                rd_data <= R;
        end
    end

    always_comb begin
        state_next    = state;
        rd_ready      = 1'b0;
        rd_data_valid = 1'b0;
        case (state)
            IDLE: begin
                rd_ready = rd_valid && !hazard;
                if (rd_ready)
                    state_next = SETTLE;
            end
            SETTLE: state_next = DONE;
            DONE: begin
                rd_data_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regop_ctrl.sv
// Bench for regop_ctrl: register-bank/op-unit environment, an architectural
// queue model compared every cycle, and directed scenarios with literal expectations.
module tb_regop_ctrl;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   run = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [7:0]             cmd_x = '0;
    logic [7:0]             cmd_y = '0;
    logic                   cmd_c = 1'b0;
    logic [2:0]             cmd_dst = '0;
    logic                   rd_valid = 1'b0;
    logic                   rd_ready;
    logic [2:0]             rd_addr = '0;
    logic                   rd_data_valid;
    logic [15:0]            rd_data;
    logic [7:0]             X;
    logic [7:0]             Y;
    logic                   C;
    logic [2:0]             w_addr;
    logic                   en_addr;
    logic [2:0]             SEL;
    logic [15:0]            R;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    regop_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .run(run),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_c(cmd_c), .cmd_dst(cmd_dst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .X(X), .Y(Y), .C(C), .w_addr(w_addr), .en_addr(en_addr),
        .SEL(SEL), .R(R), .count(count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: C=0 adds, C=1 multiplies; the bank is not cleared by reset.
    function automatic logic [15:0] op_res(input logic [7:0] x, input logic [7:0] y, input logic c);
        return c ? 16'(x) * 16'(y) : 16'(x) + 16'(y);
    endfunction

    logic [15:0] bank [8] = '{default: 16'h0};
    always @(posedge clk) if (en_addr) bank[w_addr] <= op_res(X, Y, C);
    assign R = bank[SEL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: a queue of pending writes, a view of every accepted
    // write (arch) and of every issued write (committed).
    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [2:0] dst;
    } cmd_t;

    cmd_t        q[$];
    logic [15:0] arch      [8] = '{default: 16'h0};
    logic [15:0] committed [8] = '{default: 16'h0};
    int          rd_phase = 0;
    logic [2:0]  exp_sel = '0;
    logic [15:0] pend_val = '0;
    logic [15:0] exp_rd_data = '0;

    initial begin : model
        cmd_t hd;
        bit   haz;
        bit   exp_en;
        bit   exp_rdy;
        bit   exp_push;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                q.delete();
                rd_phase    = 0;
                exp_sel     = '0;
                exp_rd_data = '0;
                arch        = committed;
            end
            haz = 1'b0;
            foreach (q[i]) if (q[i].dst == rd_addr) haz = 1'b1;
            exp_en   = run && (q.size() != 0) && !reset;
            exp_rdy  = (rd_phase == 0) && rd_valid && !haz;
            exp_push = cmd_valid && (q.size() < DEPTH) && !reset;
            hd = '{x: 8'h0, y: 8'h0, c: 1'b0, dst: 3'h0};
            if (q.size() != 0) hd = q[0];

            check("m_count", count, q.size());
            check("m_en_addr", en_addr, exp_en);
            check("m_X", X, hd.x);
            check("m_Y", Y, hd.y);
            check("m_C", C, hd.c);
            check("m_w_addr", w_addr, hd.dst);
            check("m_SEL", SEL, exp_sel);
            check("m_rd_data_valid", rd_data_valid, rd_phase == 2);
            check("m_rd_data", rd_data, exp_rd_data);
            if (!reset) begin
                check("m_cmd_ready", cmd_ready, q.size() < DEPTH);
                check("m_rd_ready", rd_ready, exp_rdy);

                case (rd_phase)
                    1: begin
                        rd_phase    = 2;
                        exp_rd_data = pend_val;
                    end
                    2: rd_phase = 0;
                    default: if (exp_rdy) begin
                        rd_phase = 1;
                        exp_sel  = rd_addr;
                        pend_val = arch[rd_addr];
                    end
                endcase
                if (exp_en) begin
                    committed[hd.dst] = op_res(hd.x, hd.y, hd.c);
                    void'(q.pop_front());
                end
                if (exp_push) begin
                    arch[cmd_dst] = op_res(cmd_x, cmd_y, cmd_c);
                    q.push_back('{x: cmd_x, y: cmd_y, c: cmd_c, dst: cmd_dst});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single write issues one cycle after acceptance.
        run = 1'b1;
        cmd_valid = 1'b1; cmd_x = 8'd3; cmd_y = 8'd5; cmd_c = 1'b0; cmd_dst = 3'd2;
        @(negedge clk); cmd_valid = 1'b0; #3;
        check("t1_en", en_addr, 1);
        check("t1_waddr", w_addr, 2);
        check("t1_x", X, 3);
        check("t1_y", Y, 5);
        @(negedge clk); #3;
        check("t1_count", count, 0);
        check("t1_en_off", en_addr, 0);

        // Fill with run=0, then drain in order across the pointer wrap.
        @(negedge clk); run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_x = 8'(i + 1); cmd_y = 8'(2 * i + 3);
            cmd_c = i[0]; cmd_dst = 3'(4 + i);
            @(negedge clk);
        end
        #3;
        check("t2_count_full", count, 4);
        check("t2_not_ready", cmd_ready, 0);
        @(negedge clk); cmd_valid = 1'b0; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("t2_en", en_addr, 1);
            check("t2_dst", w_addr, 4 + i);
            @(negedge clk);
        end
        #3;
        check("t2_drained", count, 0);

        // Read of a register with a queued write stalls until the pop.
        @(negedge clk); run = 1'b0;
        cmd_valid = 1'b1; cmd_x = 8'd10; cmd_y = 8'd4; cmd_c = 1'b1; cmd_dst = 3'd6;
        @(negedge clk); cmd_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd6; #3;
        check("t3_stall", rd_ready, 0);
        @(negedge clk); #3;
        check("t3_stall2", rd_ready, 0);
        @(negedge clk); run = 1'b1; #3;
        check("t3_pop_en", en_addr, 1);
        check("t3_pop_stall", rd_ready, 0);
        @(negedge clk); #3;
        check("t3_ready", rd_ready, 1);
        @(negedge clk); rd_valid = 1'b0; #3;
        check("t3_sel", SEL, 6);
        check("t3_settle_nv", rd_data_valid, 0);
        @(negedge clk); #3;
        check("t3_valid", rd_data_valid, 1);
        check("t3_data", rd_data, 40);
        @(negedge clk); #3;
        check("t3_valid_off", rd_data_valid, 0);

        // Same-cycle push and read of reg 1: read sees the pre-write value.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_x = 8'd7; cmd_y = 8'd9; cmd_c = 1'b0; cmd_dst = 3'd1;
        rd_valid = 1'b1; rd_addr = 3'd1; #3;
        check("t4_ready", rd_ready, 1);
        @(negedge clk); cmd_valid = 1'b0; rd_valid = 1'b0; #3;
        check("t4_issue", en_addr, 1);
        check("t4_waddr", w_addr, 1);
        @(negedge clk); #3;
        check("t4_valid", rd_data_valid, 1);
        check("t4_old_value", rd_data, 0);

        // Back-to-back reads: one accept every third cycle.
        @(negedge clk); rd_valid = 1'b1; rd_addr = 3'd1;
        for (int i = 0; i < 9; i++) begin
            #3;
            check("t5_ready", rd_ready, (i % 3) == 0);
            check("t5_valid", rd_data_valid, (i % 3) == 2);
            if ((i % 3) == 2) check("t5_data", rd_data, 16);
            @(negedge clk);
        end
        rd_valid = 1'b0;

        // Reset during SETTLE with three queued commands.
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_x = 8'(20 + i); cmd_y = 8'd1; cmd_c = 1'b0; cmd_dst = 3'(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd3; #3;
        check("t6_count3", count, 3);
        check("t6_ready", rd_ready, 1);
        @(negedge clk); rd_valid = 1'b0; reset = 1'b1; #3;
        check("t6_rst_valid", rd_data_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_en", en_addr, 0);
        check("t6_rst_x", X, 0);
        check("t6_rst_waddr", w_addr, 0);
        check("t6_rst_sel", SEL, 0);
        check("t6_rst_data", rd_data, 0);
        @(negedge clk); #3;
        check("t6_rst_valid2", rd_data_valid, 0);
        @(negedge clk); reset = 1'b0; run = 1'b1;
        cmd_valid = 1'b1; cmd_x = 8'd2; cmd_y = 8'd3; cmd_c = 1'b1; cmd_dst = 3'd0;
        @(negedge clk); cmd_valid = 1'b0; #3;
        check("t6_post_en", en_addr, 1);
        check("t6_post_waddr", w_addr, 0);
        @(negedge clk); rd_valid = 1'b1; rd_addr = 3'd0; #3;
        check("t6_post_ready", rd_ready, 1);
        @(negedge clk); rd_valid = 1'b0;
        @(negedge clk); #3;
        check("t6_post_valid", rd_data_valid, 1);
        check("t6_post_data", rd_data, 6);
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
